// File: rtl/wb_pkg.sv
// wb_pkg: shared load-size encodings, register constants and WB lane state type.
`default_nettype none

package wb_pkg;

  localparam logic [1:0] LS_BYTE  = 2'd0;
  localparam logic [1:0] LS_HALF  = 2'd1;
  localparam logic [1:0] LS_WORD  = 2'd2;
  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic        valid;
    logic        we;
    logic [4:0]  wrreg;
    logic [31:0] wrdata;
  } wb_lane_t;

endpackage

`default_nettype wire

// File: rtl/wb_load_align.sv
// wb_load_align: combinational byte/half/word select with zero or sign extension.
`default_nettype none

module wb_load_align
  import wb_pkg::*;
(
  input  logic [1:0]  lsize_i,
  input  logic        lsigned_i,
  input  logic [1:0]  addr_i,
  input  logic [31:0] memdata_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_w;
  logic [15:0] half_w;

  always_comb begin
    case (addr_i)
      2'd0:    byte_w = memdata_i[7:0];
      2'd1:    byte_w = memdata_i[15:8];
      2'd2:    byte_w = memdata_i[23:16];
      default: byte_w = memdata_i[31:24];
    endcase
    half_w = addr_i[1] ? memdata_i[31:16] : memdata_i[15:0];
  end

  // Encoding 3 is unused by the decoder and falls through to a full word.
  always_comb begin
    case (lsize_i)
      LS_BYTE: data_o = {{24{lsigned_i & byte_w[7]}}, byte_w};
      LS_HALF: data_o = {{16{lsigned_i & half_w[15]}}, half_w};
      default: data_o = memdata_i;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/wb_dual.sv
// wb_dual: dual-lane writeback pipeline registers, load alignment and same-register arbitration.
// Optional retired-instruction counter enabled by defining WB_RETIRE_CNT_EN.
`default_nettype none

module wb_dual
  import wb_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            flush,
  input  logic            m_valid0,
  input  logic            m_valid1,
  input  logic            m_regwrite0,
  input  logic            m_regwrite1,
  input  logic            m_memtoreg0,
  input  logic            m_memtoreg1,
  input  logic [1:0]      m_lsize0,
  input  logic [1:0]      m_lsize1,
  input  logic            m_lsigned0,
  input  logic            m_lsigned1,
  input  logic [XLEN-1:0] m_addr0,
  input  logic [XLEN-1:0] m_addr1,
  input  logic [XLEN-1:0] m_memdata0,
  input  logic [XLEN-1:0] m_memdata1,
  input  logic [4:0]      m_wrreg0,
  input  logic [4:0]      m_wrreg1,
  output logic            regwrite,
  output logic [4:0]      wrreg,
  output logic [XLEN-1:0] wrdata,
  output logic            regwrite1,
  output logic [4:0]      wrreg1,
  output logic [XLEN-1:0] wrdata1,
  output logic [31:0]     retire_cnt
);

  wb_lane_t   lane0_q, lane0_d;
  wb_lane_t   lane1_q, lane1_d;
  logic [31:0] load0_w, load1_w;
  logic        we0_w, we1_w;

  wb_load_align u_align0 (
    .lsize_i   (m_lsize0),
    .lsigned_i (m_lsigned0),
    .addr_i    (m_addr0[1:0]),
    .memdata_i (m_memdata0),
    .data_o    (load0_w)
  );

  wb_load_align u_align1 (
    .lsize_i   (m_lsize1),
    .lsigned_i (m_lsigned1),
    .addr_i    (m_addr1[1:0]),
    .memdata_i (m_memdata1),
    .data_o    (load1_w)
  );

  assign we0_w = m_valid0 & m_regwrite0 & (m_wrreg0 != REG_ZERO);
  assign we1_w = m_valid1 & m_regwrite1 & (m_wrreg1 != REG_ZERO);

  always_comb begin
    lane0_d = lane0_q;
    lane1_d = lane1_q;
    if (flush) begin
      lane0_d.valid = 1'b0;
      lane0_d.we    = 1'b0;
      lane1_d.valid = 1'b0;
      lane1_d.we    = 1'b0;
    end else if (!stall) begin
      lane0_d.valid  = m_valid0;
      // Lane 1 is younger, so on a shared destination only its write lands.
      lane0_d.we     = we0_w & ~(we1_w & (m_wrreg0 == m_wrreg1));
      lane0_d.wrreg  = m_wrreg0;
      lane0_d.wrdata = m_memtoreg0 ? load0_w : m_addr0;
      lane1_d.valid  = m_valid1;
      lane1_d.we     = we1_w;
      lane1_d.wrreg  = m_wrreg1;
      lane1_d.wrdata = m_memtoreg1 ? load1_w : m_addr1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane0_q <= '0;
      lane1_q <= '0;
    end else begin
      lane0_q <= lane0_d;
      lane1_q <= lane1_d;
    end
  end

  assign regwrite  = lane0_q.we;
  assign wrreg     = lane0_q.wrreg;
  assign wrdata    = lane0_q.wrdata;
  assign regwrite1 = lane1_q.we;
  assign wrreg1    = lane1_q.wrreg;
  assign wrdata1   = lane1_q.wrdata;

`ifdef WB_RETIRE_CNT_EN
  logic [31:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!stall)
      cnt_d = cnt_q + {31'd0, lane0_q.valid} + {31'd0, lane1_q.valid};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign retire_cnt = cnt_q;
`else
  assign retire_cnt = 32'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_wb_dual.sv
// tb_wb_dual: scoreboard bench for wb_dual with an independent lane/counter model.
`default_nettype none

module tb_wb_dual;

  logic        clk, rst_n, stall, flush;
  logic        m_valid0, m_valid1, m_regwrite0, m_regwrite1;
  logic        m_memtoreg0, m_memtoreg1, m_lsigned0, m_lsigned1;
  logic [1:0]  m_lsize0, m_lsize1;
  logic [31:0] m_addr0, m_addr1, m_memdata0, m_memdata1;
  logic [4:0]  m_wrreg0, m_wrreg1;
  logic        regwrite, regwrite1;
  logic [4:0]  wrreg, wrreg1;
  logic [31:0] wrdata, wrdata1, retire_cnt;

  wb_dual #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .m_valid0(m_valid0), .m_valid1(m_valid1),
    .m_regwrite0(m_regwrite0), .m_regwrite1(m_regwrite1),
    .m_memtoreg0(m_memtoreg0), .m_memtoreg1(m_memtoreg1),
    .m_lsize0(m_lsize0), .m_lsize1(m_lsize1),
    .m_lsigned0(m_lsigned0), .m_lsigned1(m_lsigned1),
    .m_addr0(m_addr0), .m_addr1(m_addr1),
    .m_memdata0(m_memdata0), .m_memdata1(m_memdata1),
    .m_wrreg0(m_wrreg0), .m_wrreg1(m_wrreg1),
    .regwrite(regwrite), .wrreg(wrreg), .wrdata(wrdata),
    .regwrite1(regwrite1), .wrreg1(wrreg1), .wrdata1(wrdata1),
    .retire_cnt(retire_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v0, we0, v1, we1;
    logic [4:0]  r0, r1;
    logic [31:0] d0, d1;
  } exp_t;

  exp_t        sbq[$];
  exp_t        last_e;
  int          n_total = 0;
  int          n_bad   = 0;
  logic [31:0] cnt_m   = 32'd0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, want);
    end
  endtask

  function automatic logic [31:0] load_model(input logic [1:0] ls, input logic sg,
                                             input logic [31:0] a, input logic [31:0] md);
    logic [31:0] sh;
    if (ls == 2'd0) begin
      sh = (md >> (a[1:0] * 8)) & 32'h0000_00FF;
      if (sg && sh[7]) sh = sh | 32'hFFFF_FF00;
    end else if (ls == 2'd1) begin
      sh = (md >> (a[1] ? 16 : 0)) & 32'h0000_FFFF;
      if (sg && sh[15]) sh = sh | 32'hFFFF_0000;
    end else begin
      sh = md;
    end
    return sh;
  endfunction

  function automatic exp_t capture_model();
    exp_t e;
    e.v0  = m_valid0;
    e.v1  = m_valid1;
    e.r0  = m_wrreg0;
    e.r1  = m_wrreg1;
    e.d0  = m_memtoreg0 ? load_model(m_lsize0, m_lsigned0, m_addr0, m_memdata0) : m_addr0;
    e.d1  = m_memtoreg1 ? load_model(m_lsize1, m_lsigned1, m_addr1, m_memdata1) : m_addr1;
    e.we1 = m_valid1 && m_regwrite1 && (m_wrreg1 != 5'd0);
    e.we0 = m_valid0 && m_regwrite0 && (m_wrreg0 != 5'd0);
    if (e.we0 && e.we1 && (m_wrreg0 == m_wrreg1)) e.we0 = 1'b0;
    return e;
  endfunction

  task automatic set_lane(input int ln, input logic v, input logic rw, input logic mtr,
                          input logic [1:0] ls, input logic sg, input logic [31:0] a,
                          input logic [31:0] md, input logic [4:0] rg);
    if (ln == 0) begin
      m_valid0 = v; m_regwrite0 = rw; m_memtoreg0 = mtr; m_lsize0 = ls;
      m_lsigned0 = sg; m_addr0 = a; m_memdata0 = md; m_wrreg0 = rg;
    end else begin
      m_valid1 = v; m_regwrite1 = rw; m_memtoreg1 = mtr; m_lsize1 = ls;
      m_lsigned1 = sg; m_addr1 = a; m_memdata1 = md; m_wrreg1 = rg;
    end
  endtask

  task automatic check_out(input string tag, input exp_t e);
    logic [31:0] want_cnt;
    check_eq({tag, ".regwrite"}, {31'd0, regwrite}, {31'd0, e.we0});
    check_eq({tag, ".regwrite1"}, {31'd0, regwrite1}, {31'd0, e.we1});
    if (e.we0) begin
      check_eq({tag, ".wrreg"}, {27'd0, wrreg}, {27'd0, e.r0});
      check_eq({tag, ".wrdata"}, wrdata, e.d0);
    end
    if (e.we1) begin
      check_eq({tag, ".wrreg1"}, {27'd0, wrreg1}, {27'd0, e.r1});
      check_eq({tag, ".wrdata1"}, wrdata1, e.d1);
    end
`ifdef WB_RETIRE_CNT_EN
    want_cnt = cnt_m;
`else
    want_cnt = 32'd0;
`endif
    check_eq({tag, ".retire_cnt"}, retire_cnt, want_cnt);
  endtask

  // One clock: predict, advance, then compare the popped prediction.
  task automatic step(input string tag);
    exp_t e;
    if (flush) begin
      e = last_e;
      e.v0 = 1'b0; e.v1 = 1'b0; e.we0 = 1'b0; e.we1 = 1'b0;
    end else if (stall) begin
      e = last_e;
    end else begin
      e = capture_model();
    end
    sbq.push_back(e);
    @(posedge clk);
    if (!stall) cnt_m = cnt_m + {31'd0, last_e.v0} + {31'd0, last_e.v1};
    last_e = e;
    #1;
    check_out(tag, sbq.pop_front());
  endtask

  task automatic reset_model();
    last_e = '{default: '0};
    cnt_m  = 32'd0;
    sbq.delete();
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
    set_lane(0, 0, 0, 0, 2'd0, 0, 32'd0, 32'd0, 5'd0);
    set_lane(1, 0, 0, 0, 2'd0, 0, 32'd0, 32'd0, 5'd0);
    reset_model();
    repeat (2) @(posedge clk);
    #1;
    check_out("reset", last_e);
    check_eq("reset.wrdata", wrdata, 32'd0);
    check_eq("reset.wrdata1", wrdata1, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    set_lane(0, 1, 1, 0, 2'd2, 0, 32'h1234_5678, 32'h0, 5'd8);
    step("alu_l0");
    set_lane(0, 0, 0, 0, 2'd0, 0, 32'h0, 32'h0, 5'd0);

    set_lane(0, 1, 1, 1, 2'd0, 1, 32'h1000_0002, 32'h1180_3344, 5'd3);
    set_lane(1, 1, 1, 1, 2'd0, 0, 32'h1000_0002, 32'h1180_3344, 5'd4);
    step("lb_lbu");
    set_lane(0, 1, 1, 1, 2'd1, 1, 32'h1000_0002, 32'h1180_3344, 5'd5);
    set_lane(1, 1, 1, 1, 2'd1, 1, 32'h1000_0001, 32'h1180_8344, 5'd6);
    step("lh_signed");
    set_lane(0, 1, 1, 1, 2'd0, 1, 32'h1000_0003, 32'hF280_3344, 5'd7);
    set_lane(1, 1, 1, 1, 2'd3, 1, 32'h1000_0001, 32'hDEAD_BEEF, 5'd10);
    step("lb3_lw3");

    set_lane(0, 1, 1, 0, 2'd2, 0, 32'h0000_000A, 32'h0, 5'd9);
    set_lane(1, 1, 1, 0, 2'd2, 0, 32'h0000_000B, 32'h0, 5'd9);
    step("conflict");

    set_lane(0, 1, 1, 0, 2'd2, 0, 32'h0000_0055, 32'h0, 5'd0);
    set_lane(1, 0, 1, 0, 2'd2, 0, 32'h0000_0066, 32'h0, 5'd11);
    step("r0_write");
    set_lane(0, 0, 1, 0, 2'd2, 0, 32'h0000_0077, 32'h0, 5'd12);
    set_lane(1, 1, 1, 0, 2'd2, 0, 32'h0000_0088, 32'h0, 5'd12);
    step("l1_only");

    set_lane(0, 1, 1, 0, 2'd2, 0, 32'hCAFE_0001, 32'h0, 5'd13);
    set_lane(1, 1, 1, 0, 2'd2, 0, 32'hCAFE_0002, 32'h0, 5'd14);
    step("pair");
    stall = 1'b1;
    set_lane(0, 1, 1, 0, 2'd2, 0, 32'hBAD0_0001, 32'h0, 5'd15);
    set_lane(1, 1, 1, 0, 2'd2, 0, 32'hBAD0_0002, 32'h0, 5'd16);
    for (int i = 0; i < 3; i++) step($sformatf("stall%0d", i));
    flush = 1'b1;
    step("flush_stall");
    stall = 1'b0;
    step("flush_only");
    flush = 1'b0;
    step("after_flush");

    for (int i = 0; i < 40; i++) begin
      stall = ($urandom_range(0, 5) == 0);
      flush = ($urandom_range(0, 7) == 0);
      set_lane(0, 1'($urandom), 1'($urandom), 1'($urandom), 2'($urandom), 1'($urandom),
               $urandom, $urandom, 5'($urandom_range(0, 3)));
      set_lane(1, 1'($urandom), 1'($urandom), 1'($urandom), 2'($urandom), 1'($urandom),
               $urandom, $urandom, 5'($urandom_range(0, 3)));
      step($sformatf("rand%0d", i));
    end
    stall = 1'b0; flush = 1'b0;

    // Asynchronous reset in mid-cycle while a stall is holding live outputs.
    set_lane(0, 1, 1, 0, 2'd2, 0, 32'h0BAD_F00D, 32'h0, 5'd17);
    set_lane(1, 1, 1, 0, 2'd2, 0, 32'h0BAD_F00E, 32'h0, 5'd18);
    step("pre_reset");
    stall = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    reset_model();
    check_out("async_reset", last_e);
    check_eq("async_reset.wrdata", wrdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    stall = 1'b0;
    step("post_reset");
    step("post_reset2");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no end expected finish");
    $fatal(1);
  end

endmodule

`default_nettype wire
